// File: rtl/mips_muldiv_unit_if.sv
// Multiply/divide issue and result bundle between the X stage and the muldiv unit.
// Latency: none (wires only); timing is owned by mips_muldiv_unit.
// Backpressure: busy from the unit stalls the CPU; start is ignored while busy.
// Ports: en/start/op/op_a/op_b/abort driven by the CPU (master);
//        busy/done/hi/lo/div0 driven by the unit (slave).
interface mips_muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             en;
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             abort;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div0;

  modport master (
    output en, start, op, op_a, op_b, abort,
    input  busy, done, hi, lo, div0
  );

  modport slave (
    input  en, start, op, op_a, op_b, abort,
    output busy, done, hi, lo, div0
  );
endinterface

// File: rtl/mips_muldiv_unit.sv
// Iterative MIPS MULT/MULTU/DIV/DIVU unit with HI/LO registers and MTHI/MTLO writes.
// Latency: WIDTH+1 enabled cycles issue-to-commit; MTHI/MTLO visible one edge after issue.
// Backpressure: busy (RUN/FIX) stalls the CPU; start while busy is ignored, en=0 freezes all state.
// Ports: clk, rst (async active-high), bus (slave modport): en, start, op, op_a, op_b, abort
//        in; busy, done, hi, lo, div0 out.
module mips_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  mips_muldiv_unit_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Operation context latched at issue
  logic             is_div_q;
  logic             is_sgn_q;
  logic             sign_a_q;
  logic             sign_b_q;
  logic             b_zero_q;
  logic [WIDTH-1:0] raw_a_q;   // op_a as issued, returned in HI on divide by zero
  logic [WIDTH-1:0] opnd_q;    // multiplicand (mul) or divisor magnitude (div)
  logic [WIDTH-1:0] acc_q;     // upper product half (mul) or remainder (div)
  logic [WIDTH-1:0] q_q;       // multiplier shifting out / dividend out, quotient in
  logic [CNT_W-1:0] cnt_q;

  logic             hi_q_en_dummy;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             done_q, div0_q;

  // Issue decode
  logic             issue;
  logic             op_arith;
  logic             op_sgn;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] mag_a, mag_b;

  assign issue    = bus.en && bus.start && !bus.abort && (state_q == S_IDLE);
  assign op_arith = ~bus.op[2];
  assign op_sgn   = ~bus.op[0];
  assign a_neg    = op_sgn & bus.op_a[WIDTH-1];
  assign b_neg    = op_sgn & bus.op_b[WIDTH-1];
  // Most-negative stays at 2^(WIDTH-1), which is its correct unsigned magnitude.
  assign mag_a    = a_neg ? (~bus.op_a + 1'b1) : bus.op_a;
  assign mag_b    = b_neg ? (~bus.op_b + 1'b1) : bus.op_b;

  // One shift-add multiply step: add multiplicand into the top half, shift the pair right.
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_acc_n, mul_q_n;

  assign mul_sum   = {1'b0, acc_q} + (q_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
  assign mul_acc_n = mul_sum[WIDTH:1];
  assign mul_q_n   = {mul_sum[0], q_q[WIDTH-1:1]};

  // One restoring divide step on the (WIDTH+1)-bit shifted partial remainder.
  // When the trial subtract succeeds the result is below the divisor, so WIDTH bits suffice.
  logic [WIDTH:0]   div_shift;
  logic             div_ok;
  logic [WIDTH-1:0] div_sub, div_acc_n, div_q_n;

  assign div_shift = {acc_q, q_q[WIDTH-1]};
  assign div_ok    = (div_shift >= {1'b0, opnd_q});
  assign div_sub   = div_shift[WIDTH-1:0] - opnd_q;
  assign div_acc_n = div_ok ? div_sub : div_shift[WIDTH-1:0];
  assign div_q_n   = {q_q[WIDTH-2:0], div_ok};

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; abort wins over everything when enabled
  always_comb begin
    state_d = state_q;
    if (bus.en) begin
      if (bus.abort) begin
        state_d = S_IDLE;
      end else begin
        unique case (state_q)
          S_IDLE:  if (bus.start && op_arith) state_d = S_RUN;
          S_RUN:   if (cnt_q == CNT_W'(1))   state_d = S_FIX;
          S_FIX:   state_d = S_IDLE;
          default: state_d = S_IDLE;
        endcase
      end
    end
  end

  // Output / commit-value logic
  logic [2*WIDTH-1:0] prod, prod_s;
  logic [WIDTH-1:0]   quo_s, rem_s;
  logic [WIDTH-1:0]   res_hi, res_lo;
  logic               res_div0;
  logic               busy_c;

  always_comb begin
    busy_c   = (state_q == S_RUN) || (state_q == S_FIX);
    prod     = {acc_q, q_q};
    prod_s   = (is_sgn_q && (sign_a_q ^ sign_b_q)) ? (~prod + 1'b1) : prod;
    quo_s    = (is_sgn_q && (sign_a_q ^ sign_b_q)) ? (~q_q + 1'b1) : q_q;
    rem_s    = (is_sgn_q && sign_a_q) ? (~acc_q + 1'b1) : acc_q;
    res_hi   = prod_s[2*WIDTH-1:WIDTH];
    res_lo   = prod_s[WIDTH-1:0];
    res_div0 = 1'b0;
    if (is_div_q) begin
      if (b_zero_q) begin
        res_hi   = raw_a_q;
        res_lo   = {WIDTH{1'b1}};
        res_div0 = 1'b1;
      end else begin
        res_hi = rem_s;
        res_lo = quo_s;
      end
    end
  end

  // Datapath and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      is_div_q <= 1'b0;
      is_sgn_q <= 1'b0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      b_zero_q <= 1'b0;
      raw_a_q  <= '0;
      opnd_q   <= '0;
      acc_q    <= '0;
      q_q      <= '0;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      div0_q   <= 1'b0;
    end else if (bus.en) begin
      done_q <= 1'b0;
      if (issue) begin
        if (op_arith) begin
          is_div_q <= bus.op[1];
          is_sgn_q <= op_sgn;
          sign_a_q <= a_neg;
          sign_b_q <= b_neg;
          b_zero_q <= (bus.op_b == '0);
          raw_a_q  <= bus.op_a;
          opnd_q   <= bus.op[1] ? mag_b : mag_a;
          q_q      <= bus.op[1] ? mag_a : mag_b;
          acc_q    <= '0;
          cnt_q    <= CNT_W'(WIDTH);
        end else if (bus.op == 3'b100) begin
          hi_q <= bus.op_a;
        end else if (bus.op == 3'b101) begin
          lo_q <= bus.op_a;
        end
      end else if (!bus.abort) begin
        if (state_q == S_RUN) begin
          acc_q <= is_div_q ? div_acc_n : mul_acc_n;
          q_q   <= is_div_q ? div_q_n   : mul_q_n;
          cnt_q <= cnt_q - 1'b1;
        end else if (state_q == S_FIX) begin
          hi_q   <= res_hi;
          lo_q   <= res_lo;
          div0_q <= res_div0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign bus.busy = busy_c;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
  assign bus.div0 = div0_q;

  assign hi_q_en_dummy = 1'b0;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Directed bench for mips_muldiv_unit: expected HI/LO/div0 pushed at issue, checked on done.
module tb_mips_muldiv_unit;

  localparam int W = 32;

  logic clk;
  logic rst;

  mips_muldiv_unit_if #(.WIDTH(W)) bus ();

  mips_muldiv_unit #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         div0;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic push(input logic [W-1:0] h, input logic [W-1:0] l, input logic d);
    exp_t e;
    e.hi = h; e.lo = l; e.div0 = d;
    exp_q.push_back(e);
  endtask

  // Monitor: every rising done is compared against the oldest expected result.
  initial begin
    logic prev_done;
    exp_t e;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && bus.done && !prev_done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("result_hi", 64'(bus.hi), 64'(e.hi));
          chk("result_lo", 64'(bus.lo), 64'(e.lo));
          chk("result_div0", 64'(bus.div0), 64'(e.div0));
        end
      end
      prev_done = bus.done;
    end
  end

  // Drive an op so it is sampled on the next rising edge (E0); returns at E0+1.
  task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    n = 0;
    while (bus.busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy) chk("issue_wait_timeout", 64'd1, 64'd0);
    bus.start = 1'b1;
    bus.op    = o;
    bus.op_a  = a;
    bus.op_b  = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!bus.done && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.done) chk("done_timeout", 64'd1, 64'd0);
  endtask

  initial begin
    int n;
    bit seen;
    rst       = 1'b1;
    bus.en    = 1'b1;
    bus.start = 1'b0;
    bus.op    = 3'b110;
    bus.op_a  = '0;
    bus.op_b  = '0;
    bus.abort = 1'b0;
    #12;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_hi", 64'(bus.hi), 64'd0);
    chk("reset_lo", 64'(bus.lo), 64'd0);
    chk("reset_busy", 64'(bus.busy), 64'd0);
    chk("reset_done", 64'(bus.done), 64'd0);
    chk("reset_div0", 64'(bus.div0), 64'd0);

    // MULT -3 * 7, with busy length and done pulse width
    push(32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    issue(3'b000, 32'hFFFF_FFFD, 32'd7);
    n = 0; seen = 0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk);
      if (bus.done) seen = 1;
      else if (bus.busy) n++;
    end
    chk("mult_done_seen", 64'(seen), 64'd1);
    chk("mult_busy_cycles", 64'(n), 64'd33);
    @(negedge clk);
    chk("done_one_cycle", 64'(bus.done), 64'd0);

    // MULTU max*max, then back-to-back MTLO on the done cycle
    push(32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    issue(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done();
    issue(3'b101, 32'h1234_5678, 32'h0);
    chk("mtlo_busy", 64'(bus.busy), 64'd0);
    @(negedge clk);
    chk("mtlo_lo", 64'(bus.lo), 64'h1234_5678);
    chk("mtlo_hi_kept", 64'(bus.hi), 64'hFFFF_FFFE);
    chk("mtlo_no_done", 64'(bus.done), 64'd0);

    // DIV -7/2, then back-to-back DIV most-negative / -1
    push(32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    issue(3'b010, 32'hFFFF_FFF9, 32'd2);
    wait_done();
    push(32'h0000_0000, 32'h8000_0000, 1'b0);
    issue(3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("b2b_busy", 64'(bus.busy), 64'd1);
    @(negedge clk);
    chk("b2b_hold_hi", 64'(bus.hi), 64'hFFFF_FFFF);
    chk("b2b_hold_lo", 64'(bus.lo), 64'hFFFF_FFFD);
    wait_done();

    // DIVU by zero, then MULTU 2*3 clears div0
    push(32'h0000_0005, 32'hFFFF_FFFF, 1'b1);
    issue(3'b011, 32'd5, 32'd0);
    wait_done();
    push(32'h0, 32'd6, 1'b0);
    issue(3'b001, 32'd2, 32'd3);
    wait_done();

    // Abort on the 10th RUN edge
    @(negedge clk);
    issue(3'b100, 32'hAAAA_5555, 32'h0);
    issue(3'b101, 32'h5555_AAAA, 32'h0);
    issue(3'b000, 32'd3, 32'd4);
    repeat (9) @(posedge clk);
    #1 bus.abort = 1'b1;
    @(posedge clk);
    #1 bus.abort = 1'b0;
    @(negedge clk);
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_hi", 64'(bus.hi), 64'hAAAA_5555);
    chk("abort_lo", 64'(bus.lo), 64'h5555_AAAA);
    chk("abort_done", 64'(bus.done), 64'd0);

    // start+abort in IDLE: neither MTHI nor MULT issues
    bus.start = 1'b1; bus.abort = 1'b1; bus.op = 3'b100; bus.op_a = 32'h1111_2222;
    @(posedge clk);
    #1 bus.op = 3'b000;
    @(posedge clk);
    #1 bus.start = 1'b0; bus.abort = 1'b0;
    @(negedge clk);
    chk("idle_abort_hi", 64'(bus.hi), 64'hAAAA_5555);
    chk("idle_abort_busy", 64'(bus.busy), 64'd0);
    repeat (40) @(negedge clk);

    // DIVU 100/7 with en low for 5 cycles mid-RUN
    push(32'd2, 32'd14, 1'b0);
    issue(3'b011, 32'd100, 32'd7);
    repeat (4) @(posedge clk);
    #1 bus.en = 1'b0;
    repeat (5) @(posedge clk);
    chk("stall_busy", 64'(bus.busy), 64'd1);
    #1 bus.en = 1'b1;
    n = 9; seen = 0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(posedge clk);
      n++;
      #1;
      if (bus.done) seen = 1;
    end
    chk("stall_latency", 64'(n), 64'd38);
    @(negedge clk);

    // Divide by zero sets div0, then reset mid-RUN clears everything
    push(32'd9, 32'hFFFF_FFFF, 1'b1);
    issue(3'b011, 32'd9, 32'd0);
    wait_done();
    issue(3'b000, 32'd5, 32'd5);
    repeat (10) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("rst_hi", 64'(bus.hi), 64'd0);
    chk("rst_lo", 64'(bus.lo), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_div0", 64'(bus.div0), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_muldiv_unit.md
# mips_muldiv_unit

Parametrised iterative multiply/divide unit with HI/LO result registers for the pipelined MIPS CPU. It sits beside the X-stage ALU and accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from X. It computes one result bit per enabled cycle and drives `busy` into the decode-stage stall logic. The CPU reads `hi`/`lo` for MFHI/MFLO.

## Interface
- `WIDTH`, 32: operand and HI/LO width; even, ≥4.
- `CNT_W`, $clog2(WIDTH)+1: iteration counter width.

- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  global pipeline enable; when low, all state holds.
- `start`  in  1  issue `op`; sampled only when `en`=1 and `busy`=0.
- `op`  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 no-op.
- `op_a`  in  WIDTH  rs operand (dividend / multiplicand / MTHI-MTLO source).
- `op_b`  in  WIDTH  rt operand (divisor / multiplier).
- `abort`  in  1  cancel in-flight or issuing op; honoured when `en`=1.
- `busy`  out  1  operation in flight; the CPU stalls MFHI/MFLO/new muldiv ops on it.
- `done`  out  1  one-cycle pulse after an arithmetic op commits HI/LO.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.
- `div0`  out  1  last completed arithmetic op was a divide by zero.

## Operation
- Reset values: `hi`=0, `lo`=0, `busy`=0, `done`=0, `div0`=0, state IDLE.
- States:
  - IDLE: accepts `start`.
  - RUN: WIDTH iterations.
  - FIX: sign correction and commit.
- Issue, IDLE with `en`&`start`&~`abort`:
  - Arithmetic op: latch the op type, |op_a| and |op_b|, and the operand signs. Magnitudes are used for the signed ops and the raw operands for the unsigned ops. Set counter=WIDTH, go to RUN.
  - MTHI/MTLO: write `op_a` to `hi`/`lo` that edge. Stay IDLE. No `busy`, no `done`, `div0` unchanged.
  - 110/111: ignored.
- RUN, per enabled edge:
  - Multiply: shift-add, 1 multiplier bit.
  - Divide: restoring step on a (WIDTH+1)-bit partial remainder, 1 quotient bit.
  - Decrement the counter; at counter=1 go to FIX.
- FIX, one enabled edge: apply signs, write `hi`/`lo`, set `done`=1, update `div0`, go to IDLE.
- Result rules, all mod 2^WIDTH per half:
  - MULT/MULTU: {hi,lo} = full 2·WIDTH product, signed or unsigned.
  - DIV/DIVU: lo=quotient truncated toward zero, hi=remainder.
  - DIV signs: the quotient takes sign(a)^sign(b); the remainder takes sign(a).
  - DIV of most-negative by −1: lo=most-negative, hi=0. No trap.
  - Divide by zero, signed or unsigned: lo=all ones, hi=`op_a` as issued, `div0`=1.
  - Any other completed arithmetic op clears `div0`.
- `abort` has priority over everything. In RUN/FIX with `en`: go to IDLE next edge, `hi`/`lo`/`div0` unchanged, no `done`. In IDLE: a simultaneous `start` is dropped, including MTHI/MTLO.
- `start` while `busy`=1: ignored. The CPU guarantees it is stalled.
- `en`=0: state, counter, `done` and outputs hold. Latency stretches by the number of disabled cycles.

## Timing
- `busy` is a registered state decode: `busy`=1 exactly when the state is RUN or FIX.
- Arithmetic latency:
  - Issue edge E0. `busy`=1 after E0.
  - RUN edges E1..E_WIDTH.
  - Commit at E_(WIDTH+1): `hi`/`lo` valid, `busy`=0, `done`=1 after it.
  - `busy` is high for WIDTH+1 enabled cycles.
- `done` clears on the next enabled edge.
- Back-to-back: a new `start` is accepted on the edge where `done`=1; the first result stays in `hi`/`lo` until the second commits.
- MTHI/MTLO: visible on `hi`/`lo` one edge after issue.
- `rst` asserted mid-operation: immediate return to reset values, asynchronously, independent of `clk`/`en`.

## Test plan
- MULT a=FFFFFFFD (−3), b=7, WIDTH=32 -> after 33 enabled edges: hi=FFFFFFFF, lo=FFFFFFEB, `done` pulse 1 cycle; `busy` high exactly 33 cycles.
- MULTU a=b=FFFFFFFF -> hi=FFFFFFFE, lo=00000001. Then MTLO a=12345678 -> lo=12345678 next edge, hi unchanged, `busy` never set.
- DIV a=FFFFFFF9 (−7), b=2 -> lo=FFFFFFFD, hi=FFFFFFFF. DIV a=80000000, b=FFFFFFFF -> lo=80000000, hi=0, `div0`=0.
- DIVU a=5, b=0 -> lo=FFFFFFFF, hi=00000005, `div0`=1. A following MULTU 2×3 -> hi=0, lo=6, `div0`=0.
- Abort: hi/lo=AAAA5555/5555AAAA via MTHI/MTLO, then MULT; abort on the 10th RUN cycle -> `busy`=0 next edge, hi/lo unchanged, no `done`. `start`+`abort` in IDLE -> nothing issues.
- Stall/reset: DIVU 100/7 with `en` low for 5 cycles mid-RUN -> result (lo=14, hi=2) at issue+38 edges. Assert `rst` mid-RUN -> all outputs 0 immediately, no `done`.
